// File: rtl/pwm_pkg.sv
// pwm_pkg: state enum and duty type shared by the frame controller and the PWM generator
package pwm_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DRAIN} pwm_state_e;
  typedef logic [15:0] duty_t;
endpackage

// File: rtl/duty_limiter.sv
// duty_limiter: clamps a duty command and slews the applied duty toward the target
module duty_limiter
  import pwm_pkg::*;
#(
  parameter int MODULO = 10000
) (
  input  duty_t cmd,
  input  duty_t min_duty,
  input  duty_t max_duty,
  input  duty_t slew,
  input  duty_t target,
  input  duty_t applied,
  output duty_t clamped,
  output duty_t slewed
);
  localparam duty_t MOD = duty_t'(MODULO);
  duty_t lo, hi;
  logic up;
  logic [16:0] diff;
  always_comb begin
    lo = (cmd < min_duty) ? min_duty : cmd;
    hi = (lo > max_duty) ? max_duty : lo;
    clamped = (cmd == '0) ? '0 : (hi > MOD) ? MOD : hi;
    up = target >= applied;
    diff = up ? {1'b0, target} - {1'b0, applied} : {1'b0, applied} - {1'b0, target};
    slewed = (slew == '0 || diff <= {1'b0, slew}) ? target : up ? applied + slew : applied - slew;
  end
endmodule

// File: rtl/pwm_frame_ctrl.sv
// pwm_frame_ctrl: prescaler, frame counter and run/drain FSM issuing double-buffered duty to a PWM generator
module pwm_frame_ctrl
  import pwm_pkg::*;
#(
  parameter int MODULO = 10000,
  parameter int DIV_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_ENABLE,
  input  logic [DIV_W-1:0] i_DIV,
  input  logic             i_WR_DUTY,
  input  logic [15:0]      i_DUTY_CMD,
  input  logic [15:0]      i_MIN_DUTY,
  input  logic [15:0]      i_MAX_DUTY,
  input  logic [15:0]      i_SLEW,
  output logic             o_PWM_TIC,
  output logic             o_START,
  output logic [15:0]      o_DUTY,
  output logic             o_BUSY,
  output logic [15:0]      o_FRAME_CNT
);
  localparam logic [15:0] LAST = 16'(MODULO - 1);
  pwm_state_e state, state_n;
  logic [DIV_W-1:0] pre_cnt, div_eff;
  logic [15:0] tic_cnt;
  duty_t target, clamped, slewed;
  logic zero_q, boundary, drop;
  duty_limiter #(.MODULO(MODULO)) u_lim (
    .cmd(i_DUTY_CMD), .min_duty(i_MIN_DUTY), .max_duty(i_MAX_DUTY), .slew(i_SLEW),
    .target(target), .applied(o_DUTY), .clamped(clamped), .slewed(slewed)
  );
  always_comb begin
    div_eff = (i_DIV == '0) ? DIV_W'(1) : i_DIV;
    o_BUSY = state != IDLE;
    o_PWM_TIC = o_BUSY && pre_cnt >= div_eff - DIV_W'(1);
    boundary = o_PWM_TIC && tic_cnt >= LAST;
    drop = state == DRAIN && !i_ENABLE;
    // zero_q marks the cycle carrying the drain's zero-duty start; leave only after it
    state_n = (state == IDLE)   ? (i_ENABLE ? LAUNCH : IDLE) :
              (state == LAUNCH) ? RUN :
              (state == RUN)    ? (i_ENABLE ? RUN : DRAIN) :
              zero_q ? IDLE : i_ENABLE ? RUN : DRAIN;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pre_cnt <= '0;
      tic_cnt <= '0;
      target <= '0;
      o_DUTY <= '0;
      o_START <= 1'b0;
      zero_q <= 1'b0;
      o_FRAME_CNT <= '0;
    end else begin
      state <= state_n;
      if (i_WR_DUTY) target <= clamped;
      zero_q <= boundary && drop;
      o_START <= (state == IDLE) ? i_ENABLE : boundary;
      pre_cnt <= (state == IDLE || o_PWM_TIC) ? '0 : pre_cnt + 1'b1;
      tic_cnt <= (state == IDLE || boundary) ? '0 : tic_cnt + 16'(o_PWM_TIC);
      if (state == IDLE) o_DUTY <= i_ENABLE ? target : '0;
      else if (boundary) o_DUTY <= drop ? '0 : slewed;
      o_FRAME_CNT <= (state_n == IDLE) ? '0 :
                     (state == IDLE || (boundary && !drop)) ? o_FRAME_CNT + 1'b1 : o_FRAME_CNT;
    end
  end
endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// tb_pwm_frame_ctrl: directed scenarios for pwm_frame_ctrl with MODULO=10
module tb_pwm_frame_ctrl;
  logic CLK = 1'b0, RST = 1'b1, i_ENABLE = 1'b0, i_WR_DUTY = 1'b0;
  logic [15:0] i_DIV = '0, i_DUTY_CMD = '0, i_MIN_DUTY = '0, i_MAX_DUTY = 16'hFFFF, i_SLEW = '0;
  logic o_PWM_TIC, o_START, o_BUSY;
  logic [15:0] o_DUTY, o_FRAME_CNT;
  int passed = 0, total = 0;
  pwm_frame_ctrl #(.MODULO(10), .DIV_W(16)) dut (
    .CLK(CLK), .RST(RST), .i_ENABLE(i_ENABLE), .i_DIV(i_DIV), .i_WR_DUTY(i_WR_DUTY),
    .i_DUTY_CMD(i_DUTY_CMD), .i_MIN_DUTY(i_MIN_DUTY), .i_MAX_DUTY(i_MAX_DUTY), .i_SLEW(i_SLEW),
    .o_PWM_TIC(o_PWM_TIC), .o_START(o_START), .o_DUTY(o_DUTY), .o_BUSY(o_BUSY), .o_FRAME_CNT(o_FRAME_CNT)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(negedge CLK);
  endtask
  task automatic wait_start(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_START && n <= 200);
    total++;
    if (n > 200) $display("FAIL start_timeout got %0d cycles want <=200", n); else passed++;
  endtask
  task automatic apply(input logic [15:0] cmd);
    int n;
    i_WR_DUTY = 1'b1;
    i_DUTY_CMD = cmd;
    tick();
    i_WR_DUTY = 1'b0;
    wait_start(n);
  endtask
  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    total += 5;
    if (o_START !== 1'b0) $display("FAIL rst_start got %b want 0", o_START); else passed++;
    if (o_PWM_TIC !== 1'b0) $display("FAIL rst_tic got %b want 0", o_PWM_TIC); else passed++;
    if (o_BUSY !== 1'b0) $display("FAIL rst_busy got %b want 0", o_BUSY); else passed++;
    if (o_DUTY !== 16'd0) $display("FAIL rst_duty got %0d want 0", o_DUTY); else passed++;
    if (o_FRAME_CNT !== 16'd0) $display("FAIL rst_fcnt got %0d want 0", o_FRAME_CNT); else passed++;
    RST = 1'b0;
  endtask
  task automatic test_basic();
    int n, tics, bad, last;
    i_DIV = 16'd3;
    i_WR_DUTY = 1'b1;
    i_DUTY_CMD = 16'd4;
    tick();
    i_WR_DUTY = 1'b0;
    i_ENABLE = 1'b1;
    tick();
    total += 4;
    if (o_START !== 1'b1) $display("FAIL launch_start got %b want 1", o_START); else passed++;
    if (o_DUTY !== 16'd4) $display("FAIL launch_duty got %0d want 4", o_DUTY); else passed++;
    if (o_BUSY !== 1'b1) $display("FAIL launch_busy got %b want 1", o_BUSY); else passed++;
    if (o_FRAME_CNT !== 16'd1) $display("FAIL launch_fcnt got %0d want 1", o_FRAME_CNT); else passed++;
    n = 0; tics = 0; bad = 0; last = -1;
    do begin
      tick();
      n++;
      if (o_PWM_TIC) begin
        tics++;
        if (n - last != 3) bad++;
        last = n;
      end
    end while (!o_START && n <= 100);
    total += 4;
    if (n !== 30) $display("FAIL frame_period got %0d want 30", n); else passed++;
    if (tics !== 10) $display("FAIL tics_per_frame got %0d want 10", tics); else passed++;
    if (bad !== 0) $display("FAIL tic_spacing got %0d bad gaps want 0", bad); else passed++;
    if (o_FRAME_CNT !== 16'd2) $display("FAIL second_fcnt got %0d want 2", o_FRAME_CNT); else passed++;
    i_DIV = 16'd1;
  endtask
  task automatic test_clamp();
    logic [15:0] cmds [4] = '{16'd1, 16'd0, 16'd9, 16'd20};
    logic [15:0] exps [4] = '{16'd2, 16'd0, 16'd8, 16'd8};
    i_MIN_DUTY = 16'd2;
    i_MAX_DUTY = 16'd8;
    for (int i = 0; i < 4; i++) begin
      apply(cmds[i]);
      total++;
      if (o_DUTY !== exps[i]) $display("FAIL clamp_%0d got %0d want %0d", cmds[i], o_DUTY, exps[i]); else passed++;
    end
    i_MIN_DUTY = 16'd0;
    i_MAX_DUTY = 16'hFFFF;
  endtask
  task automatic test_slew();
    logic [15:0] exps [4] = '{16'd3, 16'd6, 16'd9, 16'd10};
    int n;
    apply(16'd0);
    total++;
    if (o_DUTY !== 16'd0) $display("FAIL slew_base got %0d want 0", o_DUTY); else passed++;
    i_SLEW = 16'd3;
    apply(16'd10);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_start(n);
      total++;
      if (o_DUTY !== exps[i]) $display("FAIL slew_step%0d got %0d want %0d", i, o_DUTY, exps[i]); else passed++;
    end
    i_SLEW = 16'd0;
  endtask
  task automatic test_back_to_back();
    int n;
    repeat (9) tick();
    i_WR_DUTY = 1'b1;
    i_DUTY_CMD = 16'd5;
    tick();
    i_WR_DUTY = 1'b0;
    total += 2;
    if (o_START !== 1'b1) $display("FAIL bwr_start got %b want 1", o_START); else passed++;
    if (o_DUTY !== 16'd10) $display("FAIL bwr_old_duty got %0d want 10", o_DUTY); else passed++;
    wait_start(n);
    total += 2;
    if (n !== 10) $display("FAIL bwr_period got %0d want 10", n); else passed++;
    if (o_DUTY !== 16'd5) $display("FAIL bwr_new_duty got %0d want 5", o_DUTY); else passed++;
  endtask
  task automatic test_drain();
    int n;
    logic [15:0] fc;
    fc = o_FRAME_CNT;
    repeat (3) tick();
    i_ENABLE = 1'b0;
    wait_start(n);
    total += 4;
    if (n !== 7) $display("FAIL drain_len got %0d want 7", n); else passed++;
    if (o_DUTY !== 16'd0) $display("FAIL drain_duty got %0d want 0", o_DUTY); else passed++;
    if (o_BUSY !== 1'b1) $display("FAIL drain_busy got %b want 1", o_BUSY); else passed++;
    if (o_FRAME_CNT !== fc) $display("FAIL drain_fcnt got %0d want %0d", o_FRAME_CNT, fc); else passed++;
    tick();
    total += 3;
    if (o_BUSY !== 1'b0) $display("FAIL idle_busy got %b want 0", o_BUSY); else passed++;
    if (o_START !== 1'b0) $display("FAIL idle_start got %b want 0", o_START); else passed++;
    if (o_FRAME_CNT !== 16'd0) $display("FAIL idle_fcnt got %0d want 0", o_FRAME_CNT); else passed++;
  endtask
  task automatic test_mid_reset();
    i_DIV = 16'd3;
    i_ENABLE = 1'b1;
    tick();
    total++;
    if (o_DUTY !== 16'd5) $display("FAIL relaunch_duty got %0d want 5", o_DUTY); else passed++;
    repeat (7) tick();
    RST = 1'b1;
    i_ENABLE = 1'b0;
    tick();
    total += 4;
    if (o_BUSY !== 1'b0) $display("FAIL mrst_busy got %b want 0", o_BUSY); else passed++;
    if (o_PWM_TIC !== 1'b0) $display("FAIL mrst_tic got %b want 0", o_PWM_TIC); else passed++;
    if (o_DUTY !== 16'd0) $display("FAIL mrst_duty got %0d want 0", o_DUTY); else passed++;
    if (o_FRAME_CNT !== 16'd0) $display("FAIL mrst_fcnt got %0d want 0", o_FRAME_CNT); else passed++;
    RST = 1'b0;
    i_ENABLE = 1'b1;
    tick();
    total += 2;
    if (o_START !== 1'b1) $display("FAIL mrst_launch got %b want 1", o_START); else passed++;
    if (o_DUTY !== 16'd0) $display("FAIL mrst_target got %0d want 0", o_DUTY); else passed++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_slew();
    test_back_to_back();
    test_drain();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
